// File: rtl/ui_button_event_decoder.sv
// ui_button_event_decoder
// Turns the debounced, active-low button level into one-cycle gesture pulses
// (short, long, double) plus a "held" level for the mode/song-select logic.
//
// Output protocol: short_press, long_press and double_press are strobes.
// Each one is high for exactly one cycle per recognised gesture. At most one
// of them is high in any cycle. There is no back-pressure, so the consumer
// must sample every cycle.
module ui_button_event_decoder #(
  parameter int LONG_PRESS_CYCLES = 50_000_000,
  parameter int DOUBLE_GAP_CYCLES = 15_000_000
) (
  input  logic       clock_50Mhz,
  input  logic       reset,
  input  logic       buttonWire_n,
  output logic       short_press,
  output logic       long_press,
  output logic       double_press,
  output logic       held,
  output logic [2:0] dbg_state
);

  localparam int MAX_CYCLES = (LONG_PRESS_CYCLES > DOUBLE_GAP_CYCLES) ?
                              LONG_PRESS_CYCLES : DOUBLE_GAP_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES) + 1;

  // Counter values compared on the edge that completes each window
  localparam logic [CW-1:0] LONG_HIT = CW'(LONG_PRESS_CYCLES - 2);
  localparam logic [CW-1:0] GAP_HIT  = CW'(DOUBLE_GAP_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  typedef enum logic [2:0] {
    ARM       = 3'd0,
    IDLE      = 3'd1,
    PRESS1    = 3'd2,
    WAIT_GAP  = 3'd3,
    PRESS2    = 3'd4,
    LONG_HELD = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          short_q, short_d;
  logic          long_q, long_d;
  logic          double_q, double_d;

  logic pressed;
  assign pressed = ~buttonWire_n;

  // Next-state, next-count and next-pulse decode
  always_comb begin
    state_d  = state_q;
    short_d  = 1'b0;
    long_d   = 1'b0;
    double_d = 1'b0;

    case (state_q)
      ARM: begin
        // A press that was already down at reset must be released first
        if (!pressed) state_d = IDLE;
      end
      IDLE: begin
        if (pressed) state_d = PRESS1;
      end
      PRESS1: begin
        // Release has priority over reaching the long threshold
        if (!pressed) begin
          state_d = WAIT_GAP;
        end else if (cnt_q == LONG_HIT) begin
          state_d = LONG_HELD;
          long_d  = 1'b1;
        end
      end
      WAIT_GAP: begin
        // A press on the expiry edge still counts as a double press
        if (pressed) begin
          state_d  = PRESS2;
          double_d = 1'b1;
        end else if (cnt_q == GAP_HIT) begin
          state_d = IDLE;
          short_d = 1'b1;
        end
      end
      PRESS2: begin
        if (!pressed) state_d = IDLE;
      end
      LONG_HELD: begin
        if (!pressed) state_d = IDLE;
      end
      default: begin
        state_d = ARM;
      end
    endcase

    // The counter measures time spent in the current state. It saturates.
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State, counter and pulse registers. Reset drops any pulse due on that edge.
  always_ff @(posedge clock_50Mhz) begin
    if (reset) begin
      state_q  <= ARM;
      cnt_q    <= '0;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      double_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      short_q  <= short_d;
      long_q   <= long_d;
      double_q <= double_d;
    end
  end

  assign short_press  = short_q;
  assign long_press   = long_q;
  assign double_press = double_q;
  assign held         = (state_q == PRESS1) || (state_q == PRESS2) ||
                        (state_q == LONG_HELD);
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_ui_button_event_decoder.sv
// Testbench for ui_button_event_decoder with LONG=8, GAP=4.
// Expected events are pushed as {type, edge}. A monitor pops one entry and
// compares it whenever the DUT raises a pulse.
module tb_ui_button_event_decoder;

  localparam int L = 8;
  localparam int G = 4;
  localparam int W = 32;

  localparam logic [1:0] EV_SHORT  = 2'd1;
  localparam logic [1:0] EV_LONG   = 2'd2;
  localparam logic [1:0] EV_DOUBLE = 2'd3;

  logic       clk;
  logic       rst;
  logic       btn_n;
  logic       short_press;
  logic       long_press;
  logic       double_press;
  logic       held;
  logic [2:0] dbg_state;

  logic [W-1:0] exp_q[$];
  int           cyc;
  int           held_cnt;
  int           n_cmp;
  int           n_err;

  ui_button_event_decoder #(
    .LONG_PRESS_CYCLES(L),
    .DOUBLE_GAP_CYCLES(G)
  ) dut (
    .clock_50Mhz (clk),
    .reset       (rst),
    .buttonWire_n(btn_n),
    .short_press (short_press),
    .long_press  (long_press),
    .double_press(double_press),
    .held        (held),
    .dbg_state   (dbg_state)
  );

  // Clock and edge counter: after edge e, cyc == e
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: sample 2 time units after each rising edge
  initial begin
    held_cnt = 0;
    forever begin
      @(posedge clk);
      #2;
      if (held) held_cnt++;
      if ((short_press + long_press + double_press) > 1) begin
        n_cmp++;
        n_err++;
        $display("FAIL onehot: at edge %0d got s=%0b l=%0b d=%0b, require at most one",
                 cyc, short_press, long_press, double_press);
      end else if (short_press || long_press || double_press) begin
        logic [1:0]   typ;
        logic [W-1:0] got;
        logic [W-1:0] exp;
        typ = short_press ? EV_SHORT : (long_press ? EV_LONG : EV_DOUBLE);
        got = {typ, 30'(cyc)};
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_pulse: got type %0d at edge %0d, require no pulse",
                   typ, cyc);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            n_err++;
            $display("FAIL event: got type %0d at edge %0d, require type %0d at edge %0d",
                     typ, cyc, exp[31:30], exp[29:0]);
          end
        end
      end
    end
  end

  task automatic push_ev(input logic [1:0] typ, input int edge_n);
    exp_q.push_back({typ, 30'(edge_n)});
  endtask

  // Drive level for n cycles. Starts and ends at a falling edge.
  task automatic drive(input logic lvl, input int n);
    for (int i = 0; i < n; i++) begin
      btn_n = lvl;
      @(negedge clk);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, require %0d", name, got, exp);
    end
  endtask

  task automatic check_drained(input string name);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s: %0d expected events never seen, require 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    int e;
    int h0;
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    btn_n = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    check_int("reset_short", int'(short_press), 0);
    check_int("reset_long", int'(long_press), 0);
    check_int("reset_double", int'(double_press), 0);
    check_int("reset_held", int'(held), 0);
    check_int("reset_state_arm", int'(dbg_state), 0);

    // 1: held through reset gives no events; a later press works normally
    btn_n = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    h0 = held_cnt;
    drive(1'b0, 20);
    drive(1'b1, 3);
    check_int("t1_held_cycles", held_cnt - h0, 0);
    check_drained("t1_no_event");
    e = cyc + 1;
    push_ev(EV_SHORT, e + 2 + G);
    drive(1'b0, 2);
    drive(1'b1, 8);
    check_drained("t1_after_short");

    // 2: short press of 3 cycles
    e = cyc + 1;
    h0 = held_cnt;
    push_ev(EV_SHORT, e + 3 + G);
    drive(1'b0, 3);
    drive(1'b1, 10);
    check_int("t2_held_cycles", held_cnt - h0, 3);
    check_drained("t2_short");

    // 3: long press of 12 cycles
    e = cyc + 1;
    h0 = held_cnt;
    push_ev(EV_LONG, e + L - 1);
    drive(1'b0, 12);
    drive(1'b1, 10);
    check_int("t3_held_cycles", held_cnt - h0, 12);
    check_drained("t3_long");

    // Release on the long threshold edge: the release wins, giving a short press
    e = cyc + 1;
    h0 = held_cnt;
    push_ev(EV_SHORT, e + (L - 1) + G);
    drive(1'b0, L - 1);
    drive(1'b1, 10);
    check_int("long_edge_held_cycles", held_cnt - h0, L - 1);
    check_drained("long_edge_release");

    // 4: double press with a gap of 2
    e = cyc + 1;
    h0 = held_cnt;
    push_ev(EV_DOUBLE, e + 4);
    drive(1'b0, 2);
    drive(1'b1, 2);
    drive(1'b0, 2);
    drive(1'b1, 10);
    check_int("t4_held_cycles", held_cnt - h0, 4);
    check_drained("t4_double");

    // Press on the gap-expiry edge: double wins
    e = cyc + 1;
    push_ev(EV_DOUBLE, e + 2 + G);
    drive(1'b0, 2);
    drive(1'b1, G);
    drive(1'b0, 2);
    drive(1'b1, 10);
    check_drained("gap_edge_double");

    // 5: gap of 5 gives a short press, then a fresh press
    e = cyc + 1;
    push_ev(EV_SHORT, e + 2 + G);
    push_ev(EV_SHORT, e + 2 + 5 + 2 + G);
    drive(1'b0, 2);
    drive(1'b1, 5);
    drive(1'b0, 2);
    drive(1'b1, 10);
    check_drained("t5_two_shorts");

    // 6: reset on the 6th sample of a 12-cycle press
    e = cyc + 1;
    h0 = held_cnt;
    drive(1'b0, 5);
    rst = 1'b1;
    drive(1'b0, 1);
    rst = 1'b0;
    check_int("t6_short_after_rst", int'(short_press), 0);
    check_int("t6_long_after_rst", int'(long_press), 0);
    check_int("t6_double_after_rst", int'(double_press), 0);
    check_int("t6_held_after_rst", int'(held), 0);
    drive(1'b0, 6);
    drive(1'b1, 3);
    check_int("t6_held_cycles", held_cnt - h0, 5);
    check_drained("t6_no_event");
    e = cyc + 1;
    push_ev(EV_SHORT, e + 2 + G);
    drive(1'b0, 2);
    drive(1'b1, 8);
    check_drained("t6_after_short");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
